nibble_serial_alu_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_alu_ctrl
// PURPOSE
//  Sequencer that time-shares one four-bit ALU slice (external instance, driven via alu_* ports)
//  to execute WIDTH-bit AND/OR/ADD/SUB/SLT, one nibble per cycle, LSB nibble first.
//  Sits between the datapath issue logic (start/op/a/b) and the four-bit ALU.
//  Holds the carry between nibbles, assembles the result and flags, and signals completion.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8
//  NIB    WIDTH/4 (derived, localparam)  number of nibble passes per operation
// PORTS
//  clk           in   1      clock; all state changes on rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  start         in   1      request; accepted only when ready=1
//  op            in   3      op[2]=binv; op[1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT
//  a, b          in   WIDTH  operands, sampled on the accepting edge
//  ready         out  1      1 in IDLE only
//  busy          out  1      1 in RUN
//  done          out  1      one-cycle pulse; result/flags valid in that cycle and held afterwards
//  result        out  WIDTH  assembled result
//  cout          out  1      carry out of the MSB nibble (ADD/SUB/SLT); 0 for AND/OR
//  overflow      out  1      signed overflow of the MSB nibble (ADD/SUB/SLT); 0 for AND/OR
//  zero          out  1      1 iff result == 0
//  alu_a, alu_b  out  4      current nibble of the latched operands
//  alu_cin       out  1      op[2] on nibble 0; registered carry from the previous nibble afterwards
//  alu_less      out  1      always 0; SLT is resolved here, not via the ALU less chain
//  alu_op        out  3      latched op; SLT (x11) is driven as 3'b110 (subtract)
//  alu_result    in   4      nibble result
//  alu_cout      in   1      nibble carry out
//  alu_set       in   1      sign (sum bit 3) of the nibble
//  alu_overflow  in   1      nibble overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, carry=0. result, cout, overflow, done and busy all 0.
//    zero=1, ready=1. Reset mid-operation aborts immediately; the partial result is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: on start=1, latch a, b and op; idx<=0; go to RUN. start while not IDLE is ignored (not queued).
//    RUN: alu_* is driven combinationally from the latched operands and idx.
//      Each edge writes alu_result into result[4*idx+:4] and sets carry<=alu_cout.
//      On the edge with idx=NIB-1: latch cout<=alu_cout, overflow<=alu_overflow and set_q<=alu_set; go to DONE.
//      Otherwise idx<=idx+1.
//    DONE: done=1 for exactly one cycle, then IDLE. ready=0 in DONE.
//      Earliest next accept is therefore the edge after DONE.
//  Latency: start accepted at edge E0, so done=1 in the cycle after edge E(NIB).
//    For WIDTH=16, done is high 4 cycles after acceptance. Throughput is one op per NIB+2 cycles.
//  SLT: passes run as subtract (alu_cin=1 on nibble 0). On entering DONE, result<={0, set_q^overflow}.
//    This is a signed less-than.
//  AND/OR: carry is unused; cout and overflow are forced 0.
//  zero is computed from the registered result; it is valid whenever done=1 and is held.
//  Outputs are held from DONE until the next accept. On accept, result is cleared to 0.
//  Nibble index wraps only via FSM exit; idx never exceeds NIB-1.
// TESTING (WIDTH=16, behavioural 4-bit ALU model on alu_*)
//  ADD 0x7FFF+0x0001 -> result 0x8000, overflow=1, cout=0, zero=0; done exactly 4 cycles after accept.
//  SUB (op=110) 0x0005-0x0005 -> result 0x0000, zero=1, cout=1, overflow=0. Check alu_cin=1 on nibble 0 only.
//  SLT (op=111) a=0xFFFF,b=0x0001 -> 0x0001. a=0x8000,b=0x7FFF -> 0x0001 (overflow case).
//    Swapped operands -> 0x0000.
//  AND 0xF0F0&0x0FF0 -> 0x00F0. OR -> 0xFFF0. cout=0, overflow=0 for both.
//  start held high continuously -> ops accepted only in IDLE. done pulses are spaced 6 cycles apart.
//    Operand changes while busy do not affect the result.
//  rst_n low during RUN (idx=2) -> all outputs reset asynchronously. A new op after release completes correctly.

Source files
------------

// File: rtl/nibble_serial_alu_ctrl_if.sv
// Bundles the issue-side handshake and the 4-bit ALU slice connection
// of the nibble-serial ALU sequencer.
interface nibble_serial_alu_ctrl_if #(
  parameter int WIDTH = 16
);
  // Issue side
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  // ALU slice side
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             alu_cin;
  logic             alu_less;
  logic [2:0]       alu_op;
  logic [3:0]       alu_result;
  logic             alu_cout;
  logic             alu_set;
  logic             alu_overflow;

  // Sequencer view
  modport slave (
    input  start, op, a, b, alu_result, alu_cout, alu_set, alu_overflow,
    output ready, busy, done, result, cout, overflow, zero,
           alu_a, alu_b, alu_cin, alu_less, alu_op
  );

  // Issue logic / ALU slice view
  modport master (
    output start, op, a, b, alu_result, alu_cout, alu_set, alu_overflow,
    input  ready, busy, done, result, cout, overflow, zero,
           alu_a, alu_b, alu_cin, alu_less, alu_op
  );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial sequencer: runs a WIDTH-bit AND/OR/ADD/SUB/SLT through one
// external 4-bit ALU slice, LSB nibble first, carrying between nibbles.
module nibble_serial_alu_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_alu_ctrl_if.slave   bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               last_nib;
  logic               is_arith;
  logic               is_slt;

  assign last_nib = (idx_q == IDX_W'(NIB - 1));
  assign is_arith = op_q[1];
  assign is_slt   = (op_q[1:0] == 2'b11);

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: accept in IDLE, one nibble per RUN cycle, one DONE cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          idx_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[4*idx_q +: 4] = bus.alu_result;
        carry_d                = bus.alu_cout;
        if (last_nib) begin
          // Flags come from the MSB nibble; logic ops have no carry chain
          cout_d  = is_arith ? bus.alu_cout     : 1'b0;
          ovf_d   = is_arith ? bus.alu_overflow : 1'b0;
          // Signed less-than is the true sign of the difference
          if (is_slt) begin
            result_d = WIDTH'(bus.alu_set ^ bus.alu_overflow);
          end
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake, result and ALU slice drive
  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = (result_q == '0);
  assign bus.alu_a    = a_q[4*idx_q +: 4];
  assign bus.alu_b    = b_q[4*idx_q +: 4];
  assign bus.alu_cin  = (idx_q == '0) ? op_q[2] : carry_q;
  assign bus.alu_less = 1'b0;
  assign bus.alu_op   = is_slt ? 3'b110 : op_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: behavioural 4-bit ALU slice on alu_*, full-width
// arithmetic reference model, directed cases plus randomized operations.
module tb_nibble_serial_alu_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  nibble_serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU slice
  logic [3:0] slice_bb;
  logic [4:0] slice_sum;
  always_comb begin
    slice_bb  = bus.alu_op[2] ? ~bus.alu_b : bus.alu_b;
    slice_sum = {1'b0, bus.alu_a} + {1'b0, slice_bb} + {4'b0, bus.alu_cin};
    case (bus.alu_op[1:0])
      2'b00:   bus.alu_result = bus.alu_a & slice_bb;
      2'b01:   bus.alu_result = bus.alu_a | slice_bb;
      default: bus.alu_result = slice_sum[3:0];
    endcase
    bus.alu_cout     = bus.alu_op[1] ? slice_sum[4] : 1'b0;
    bus.alu_set      = slice_sum[3];
    bus.alu_overflow = bus.alu_op[1] && (bus.alu_a[3] == slice_bb[3]) &&
                       (slice_sum[3] != bus.alu_a[3]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: result and flags from plain arithmetic
  task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic co, output logic ov);
    logic [15:0] bb;
    logic [16:0] s;
    bb = op[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {16'b0, op[2]};
    co = s[16];
    ov = (a[15] == bb[15]) && (s[15] != a[15]);
    case (op[1:0])
      2'b00: begin res = a & bb; co = 1'b0; ov = 1'b0; end
      2'b01: begin res = a | bb; co = 1'b0; ov = 1'b0; end
      2'b10: res = s[15:0];
      default: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
  endtask

  // Carry into nibble k of a + (op[2] ? ~b : b) + op[2]
  function automatic logic carry_into(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input int k);
    logic [16:0] m;
    logic [16:0] t;
    logic [15:0] bb;
    if (k == 0) return op[2];
    bb = op[2] ? ~b : b;
    m  = (17'h1 << (4 * k)) - 17'h1;
    t  = ({1'b0, a} & m) + ({1'b0, bb} & m) + {16'b0, op[2]};
    return t[4 * k];
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", {31'b0, bus.ready}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        ec, eo;
    logic [2:0]  eop;
    int          cyc;
    ref_model(op, a, b, er, ec, eo);
    eop = (op[1:0] == 2'b11) ? 3'b110 : op;
    wait_ready();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    check("busy_after_accept", {30'b0, bus.busy, bus.ready}, 32'd2);
    check("result_cleared", {16'b0, bus.result}, 32'd0);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy && cyc < 4) begin
        check("alu_a", {28'b0, bus.alu_a}, {28'b0, a[4*cyc +: 4]});
        check("alu_b", {28'b0, bus.alu_b}, {28'b0, b[4*cyc +: 4]});
        check("alu_op", {29'b0, bus.alu_op}, {29'b0, eop});
        check("alu_less", {31'b0, bus.alu_less}, 32'd0);
        if (cyc == 0 || op[1])
          check("alu_cin", {31'b0, bus.alu_cin}, {31'b0, carry_into(op, a, b, cyc)});
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 32'd4);
    check("result", {16'b0, bus.result}, {16'b0, er});
    check("cout", {31'b0, bus.cout}, {31'b0, ec});
    check("overflow", {31'b0, bus.overflow}, {31'b0, eo});
    check("zero", {31'b0, bus.zero}, {31'b0, (er == 16'd0)});
    check("ready_in_done", {31'b0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {30'b0, bus.done, bus.ready}, 32'd1);
    check("result_held", {16'b0, bus.result}, {16'b0, er});
  endtask

  logic [2:0] op_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};

  initial begin
    int last;
    int npulse;
    int n;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #12;
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
    check("rst_result", {16'b0, bus.result}, 32'd0);
    check("rst_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'b010, 16'h7FFF, 16'h0001);
    run_op(3'b110, 16'h0005, 16'h0005);
    run_op(3'b111, 16'hFFFF, 16'h0001);
    run_op(3'b111, 16'h8000, 16'h7FFF);
    run_op(3'b111, 16'h0001, 16'hFFFF);
    run_op(3'b111, 16'h7FFF, 16'h8000);
    run_op(3'b000, 16'hF0F0, 16'h0FF0);
    run_op(3'b001, 16'hF0F0, 16'h0FF0);
    run_op(3'b010, 16'hFFFF, 16'h0001);

    // start held high: accepts only from IDLE, done every 6 cycles
    wait_ready();
    bus.op    = 3'b010;
    bus.a     = 16'h1234;
    bus.b     = 16'h1111;
    bus.start = 1'b1;
    last      = -1;
    npulse    = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        npulse++;
        check("held_result", {16'b0, bus.result}, 32'h2345);
        if (last >= 0) check("done_spacing", i - last, 32'd6);
        last = i;
      end
    end
    check("held_pulses", npulse, 32'd3);
    bus.start = 1'b0;

    // Asynchronous reset in the middle of an operation
    wait_ready();
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {30'b0, bus.ready, bus.busy}, 32'd2);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_result", {16'b0, bus.result}, 32'd0);
    check("midrst_flags", {29'b0, bus.cout, bus.overflow, bus.zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b110, 16'h1000, 16'h0001);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 6));
      run_op(op_tab[n], 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
